// File: rtl/zap_thumb_fetch_seq.sv
// zap_thumb_fetch_seq: turns 32-bit I-cache words into an ARM or Thumb
// instruction stream. In Thumb mode each word is emitted as two halfwords.
// Optional build macro: ZAP_THUMB_BL_FUSE_EN. It merges a Thumb BL
// prefix/suffix halfword pair into one 32-bit output.
//
// Handshakes (both sides follow strict valid/ready rules):
//   - An input word moves on a cycle where i_word_valid && o_word_ready.
//     o_word_ready does not depend on i_word_valid.
//   - An output instruction is consumed on a cycle where
//     o_instruction_valid && !i_stall.
//     o_instruction_valid does not depend on i_stall.
module zap_thumb_fetch_seq (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  input  logic        i_cpsr_t,
  input  logic [31:0] i_word,
  input  logic        i_word_valid,
  output logic        o_word_ready,
  input  logic        i_stall,
  output logic [31:0] o_instruction,
  output logic        o_instruction_valid,
  output logic [31:0] o_pc,
  output logic        o_bl_fused,
  output logic [1:0]  o_dbg_state
);

`ifdef ZAP_THUMB_BL_FUSE_EN
  localparam bit FUSE_EN = 1'b1;
`else
  localparam bit FUSE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_EMPTY       = 2'd0,
    S_FULL_LO     = 2'd1,
    S_FULL_HI     = 2'd2,
    S_PREFIX_WAIT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [31:0] pc_q, pc_d;
  logic        mode_q, mode_d;   // 0 = ARM, 1 = Thumb
  logic [15:0] pfx_q, pfx_d;     // BL prefix parked while waiting for its suffix
  logic        pair_q, pair_d;   // FULL_LO is showing {word[15:0], pfx_q}

  logic lo_is_pfx, hi_is_pfx, hi_is_sfx;
  logic fuse_lo, hold_hi, valid, consume, last_slot, ready, accept;

  // Decode the output slot and work out the handshake signals.
  always_comb begin
    lo_is_pfx = (word_q[15:11] == 5'b11110);
    hi_is_pfx = (word_q[31:27] == 5'b11110);
    hi_is_sfx = (word_q[31:27] == 5'b11111);
    fuse_lo   = FUSE_EN && mode_q && (state_q == S_FULL_LO) &&
                (pair_q || (lo_is_pfx && hi_is_sfx));
    hold_hi   = FUSE_EN && mode_q && (state_q == S_FULL_HI) && hi_is_pfx;
    valid     = (state_q == S_FULL_LO) || ((state_q == S_FULL_HI) && !hold_hi);
    consume   = valid && !i_stall;
    // The slot is the last one for the held word when nothing is left after it.
    last_slot = !mode_q || (state_q == S_FULL_HI) || (fuse_lo && !pair_q);
    ready     = !i_flush && ((state_q == S_EMPTY) || (state_q == S_PREFIX_WAIT) ||
                             (consume && last_slot));
    accept    = i_word_valid && ready;
  end

  // Select the output instruction from the held word.
  always_comb begin
    o_instruction = 32'd0;
    if (valid) begin
      if (fuse_lo && pair_q)          o_instruction = {word_q[15:0], pfx_q};
      else if (fuse_lo || !mode_q)    o_instruction = word_q;
      else if (state_q == S_FULL_HI)  o_instruction = {16'd0, word_q[31:16]};
      else                            o_instruction = {16'd0, word_q[15:0]};
    end
  end

  // Next-state logic: flush first, then consume, then accept.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    pc_d    = pc_q;
    mode_d  = mode_q;
    pfx_d   = pfx_q;
    pair_d  = pair_q;
    if (i_flush) begin
      state_d = S_EMPTY;
      pc_d    = i_flush_pc;
      mode_d  = i_cpsr_t;
      pair_d  = 1'b0;
    end else begin
      if (consume) begin
        pc_d    = pc_q + ((!mode_q || fuse_lo) ? 32'd4 : 32'd2);
        pair_d  = 1'b0;
        state_d = last_slot ? S_EMPTY : S_FULL_HI;
      end else if (hold_hi && !i_stall) begin
        // The prefix is parked and o_pc stays on its address.
        state_d = S_PREFIX_WAIT;
        pfx_d   = word_q[31:16];
      end
      if (accept) begin
        word_d = i_word;
        if (state_q == S_PREFIX_WAIT) begin
          state_d = S_FULL_LO;
          pair_d  = 1'b1;
        end else begin
          state_d = (mode_q && pc_d[1]) ? S_FULL_HI : S_FULL_LO;
        end
      end
    end
  end

  // State registers; reset has priority over everything.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_EMPTY;
      word_q  <= 32'd0;
      pc_q    <= 32'd0;
      mode_q  <= 1'b0;
      pfx_q   <= 16'd0;
      pair_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pc_q    <= pc_d;
      mode_q  <= mode_d;
      pfx_q   <= pfx_d;
      pair_q  <= pair_d;
    end
  end

  assign o_word_ready        = ready;
  assign o_instruction_valid = valid;
  assign o_pc                = pc_q;
  assign o_bl_fused          = fuse_lo;
  assign o_dbg_state         = state_q;

endmodule
